// File: rtl/rom_plane_switch.sv
// ROM plane switcher: synchronises the CPU oe_n strobe, qualifies reads inside a trigger window
// and steps the ROM plane when the strobe ends. Optional macro PROFI_TABLE_EN selects the legacy Profi table.
module rom_plane_switch #(
   parameter int          PLANE_BITS = 2,
   parameter logic [11:0] WIN_TAG    = 12'h810,
   parameter int          MIN_LOW    = 2
) (
   input  logic                  fclk,
   input  logic                  rst,
   input  logic                  oe_n,
   input  logic [15:0]           a,
   output logic [PLANE_BITS-1:0] plane,
   output logic                  switch_stb
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CNT    = 3'd1;
   localparam logic [2:0] ST_ARMED  = 3'd2;
   localparam logic [2:0] ST_COMMIT = 3'd3;
   localparam logic [2:0] ST_WAITHI = 3'd4;

   localparam logic [3:0] MIN_LOW_C = 4'(MIN_LOW);

   logic [2:0]            state;
   logic [3:0]            cnt;
   logic [1:0]            sel;
   logic                  oe_meta;
   logic                  oe_s;
   logic                  in_win;
   logic [PLANE_BITS-1:0] plane_next;
   logic                  unused_ok;

   assign in_win     = (a[15:4] == WIN_TAG);
   assign switch_stb = (state == ST_COMMIT);
   assign unused_ok  = &{1'b0, a[1:0]};

`ifdef PROFI_TABLE_EN
   // The legacy table is only defined for four planes.
   if (PLANE_BITS != 2) begin : g_profi_width_check
      $error("rom_plane_switch: PROFI_TABLE_EN requires PLANE_BITS == 2");
   end

   logic [1:0] profi_next;

   always_comb begin
      profi_next = plane[1:0];
      case ({sel, plane[1:0]})
         4'b01_00: profi_next = 2'd3;
         4'b01_01: profi_next = 2'd3;
         4'b01_10: profi_next = 2'd3;
         4'b01_11: profi_next = 2'd2;
         4'b10_00: profi_next = 2'd2;
         4'b10_01: profi_next = 2'd2;
         4'b10_10: profi_next = 2'd0;
         4'b10_11: profi_next = 2'd1;
         4'b11_00: profi_next = 2'd1;
         4'b11_01: profi_next = 2'd0;
         4'b11_10: profi_next = 2'd1;
         4'b11_11: profi_next = 2'd0;
         default:  profi_next = plane[1:0];
      endcase
      plane_next = PLANE_BITS'(profi_next);
   end
`else
   always_comb begin
      plane_next = plane;
      case (sel)
         2'b01:   plane_next = plane + PLANE_BITS'(1);
         2'b10:   plane_next = plane - PLANE_BITS'(1);
         2'b11:   plane_next = '0;
         default: plane_next = plane;
      endcase
   end
`endif

   // The plane is written on the ARMED->COMMIT transition, so it changes together with switch_stb.
   always_ff @(posedge fclk) begin
      if (rst) begin
         oe_meta <= 1'b1;
         oe_s    <= 1'b1;
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         sel     <= 2'b00;
         plane   <= '0;
      end else begin
         oe_meta <= oe_n;
         oe_s    <= oe_meta;
         case (state)
            ST_IDLE: begin
               if (!oe_s) begin
                  state <= ST_CNT;
                  cnt   <= 4'd1;
               end
            end
            ST_CNT: begin
               if (cnt == MIN_LOW_C) begin
                  if (in_win) begin
                     state <= ST_ARMED;
                     sel   <= a[3:2];
                  end else begin
                     state <= ST_WAITHI;
                  end
               end else if (oe_s) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_ARMED: begin
               if (oe_s) begin
                  state <= ST_COMMIT;
                  plane <= plane_next;
               end else if (!in_win) begin
                  state <= ST_WAITHI;
               end
            end
            ST_COMMIT: state <= ST_IDLE;
            ST_WAITHI: begin
               if (oe_s) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_plane_switch.sv
// Testbench for rom_plane_switch: plans a whole strobe schedule up front, derives the expected
// plane/switch_stb per clock from strobe-level rules, then drives and compares every cycle.
module tb_rom_plane_switch;

   localparam int PLANE_BITS = 2;
   localparam int NPLANES    = 1 << PLANE_BITS;
   localparam int MIN_LOW    = 2;
   localparam int NCYC       = 3000;

   typedef struct {
      logic [15:0] a1;
      logic [15:0] a2;
      int          chg;
      int          len;
      bit          rs;
      int          pv;
   } dir_t;

   logic        fclk = 1'b1;
   logic        rst  = 1'b1;
   logic        oe_n = 1'b1;
   logic [15:0] a    = 16'h0000;
   logic [1:0]  plane;
   logic        switch_stb;

   logic        pin_at[NCYC];
   logic        rst_at[NCYC];
   logic        cmt_at[NCYC];
   logic [15:0] a_at[NCYC];
   logic [1:0]  sel_at[NCYC];
   int          exp_plane[NCYC];
   logic        exp_stb[NCYC];
   int          pin_edge[$];
   int          pin_val[$];
   dir_t        dirs[$];

   int compared   = 0;
   int mismatched = 0;

   always #5 fclk = ~fclk;

   rom_plane_switch #(
      .PLANE_BITS(PLANE_BITS),
      .WIN_TAG   (12'h810),
      .MIN_LOW   (MIN_LOW)
   ) dut (
      .fclk      (fclk),
      .rst       (rst),
      .oe_n      (oe_n),
      .a         (a),
      .plane     (plane),
      .switch_stb(switch_stb)
   );

   function automatic int next_plane(input int p, input int s);
`ifdef PROFI_TABLE_EN
      int tbl[4][4] = '{'{0, 1, 2, 3}, '{3, 3, 3, 2}, '{2, 2, 0, 1}, '{1, 0, 1, 0}};
      return tbl[s][p];
`else
      case (s)
         0:       return p;
         1:       return (p + 1) % NPLANES;
         2:       return (p + NPLANES - 1) % NPLANES;
         default: return 0;
      endcase
`endif
   endfunction

   function automatic logic [15:0] rand_addr();
      int r = $urandom_range(0, 9);
      logic [15:0] v = 16'($urandom);
      if (r < 6) return {12'h810, v[3:0]};
      if (r < 8) return v;
      return (r == 8) ? 16'h8110 : 16'h80FC;
   endfunction

   // One strobe: pin low for len clocks starting at edge s; outcome decided from strobe-level rules.
   task automatic add_txn(input int s, input int len, input logic [15:0] addr, input logic [15:0] addr2,
                          input int chg, input bit do_rst, output int nxt);
      int  q;
      int  c;
      bit  ok;
      for (int e = s; e < s + len; e++) pin_at[e] = 1'b0;
      for (int e = s; e <= s + len + 1; e++) a_at[e] = (chg > 0 && e >= s + chg) ? addr2 : addr;
      if (do_rst) begin
         for (int e = s + 7; e <= s + 9; e++) rst_at[e] = 1'b1;
         nxt = s + 12;
      end else begin
         nxt = s + len + int'($urandom_range(4, 6));
         for (int e = s + len + 2; e < nxt; e++) a_at[e] = 16'($urandom);
         if (len >= MIN_LOW) begin
            q  = s + 2 + MIN_LOW;
            ok = (a_at[q][15:4] == 12'h810);
            for (int e = q + 1; e <= s + len + 1; e++)
               if (a_at[e][15:4] != 12'h810) ok = 1'b0;
            if (ok) begin
               c = (s + len + 2 > q + 1) ? s + len + 2 : q + 1;
               cmt_at[c] = 1'b1;
               sel_at[c] = a_at[q][3:2];
            end
         end
      end
   endtask

   task automatic applyStimulus();
      int s = 5;
      int nxt;
      int cur;
      int len;
      bit rs;
      logic [15:0] a1;
      logic [15:0] a2;
      int chg;
      for (int t = 0; t < NCYC; t++) begin
         pin_at[t] = 1'b1;
         rst_at[t] = (t < 3);
         cmt_at[t] = 1'b0;
         a_at[t]   = 16'h0000;
         sel_at[t] = 2'b00;
      end
`ifdef PROFI_TABLE_EN
      dirs.push_back('{16'h8104, 16'h0, 0, 4, 1'b0, 3});
      dirs.push_back('{16'h8108, 16'h0, 0, 4, 1'b0, 1});
      dirs.push_back('{16'h810C, 16'h0, 0, 4, 1'b0, 0});
      dirs.push_back('{16'h810C, 16'h0, 0, 4, 1'b0, 1});
      dirs.push_back('{16'h8104, 16'h0, 0, 8, 1'b1, 0});
`else
      dirs.push_back('{16'h8104, 16'h0,    0, 4, 1'b0, 1});
      dirs.push_back('{16'h810C, 16'h0,    0, 1, 1'b0, 1});
      dirs.push_back('{16'h8000, 16'h0,    0, 4, 1'b0, 1});
      dirs.push_back('{16'h8104, 16'h9000, 5, 6, 1'b0, 1});
      dirs.push_back('{16'h8104, 16'h0,    0, 4, 1'b0, 2});
      dirs.push_back('{16'h8104, 16'h0,    0, 4, 1'b0, 3});
      dirs.push_back('{16'h8104, 16'h0,    0, 4, 1'b0, 0});
      dirs.push_back('{16'h8108, 16'h0,    0, 4, 1'b0, 3});
      dirs.push_back('{16'h810C, 16'h0,    0, 4, 1'b0, 0});
      dirs.push_back('{16'h8104, 16'h0,    0, 4, 1'b0, 1});
      dirs.push_back('{16'h8104, 16'h0,    0, 8, 1'b1, 0});
`endif
      foreach (dirs[i]) begin
         add_txn(s, dirs[i].len, dirs[i].a1, dirs[i].a2, dirs[i].chg, dirs[i].rs, nxt);
         pin_edge.push_back(dirs[i].rs ? s + 11 : s + dirs[i].len + 3);
         pin_val.push_back(dirs[i].pv);
         s = nxt;
      end
      while (s + 20 < NCYC) begin
         rs  = ($urandom_range(0, 19) == 0);
         len = rs ? 8 : int'($urandom_range(1, 7));
         a1  = rs ? 16'h8104 : rand_addr();
         a2  = rand_addr();
         chg = (!rs && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len + 1)) : 0;
         add_txn(s, len, a1, a2, chg, rs, nxt);
         s = nxt;
      end
      cur = 0;
      for (int t = 0; t < NCYC; t++) begin
         exp_stb[t] = 1'b0;
         if (rst_at[t]) cur = 0;
         else if (cmt_at[t]) begin
            cur        = next_plane(cur, int'(sel_at[t]));
            exp_stb[t] = 1'b1;
         end
         exp_plane[t] = cur;
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int required);
      compared++;
      if (actual != required) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   initial begin
      applyStimulus();
      for (int t = 0; t < NCYC; t++) begin
         @(negedge fclk);
         rst  = rst_at[t];
         oe_n = pin_at[t];
         a    = a_at[t];
      end
   end

   initial begin
      int pi = 0;
      for (int t = 0; t < NCYC; t++) begin
         @(posedge fclk);
         #1;
         checkOutput($sformatf("plane@%0d", t), int'(plane), exp_plane[t]);
         checkOutput($sformatf("switch_stb@%0d", t), int'(switch_stb), int'(exp_stb[t]));
         if (pi < pin_edge.size() && t == pin_edge[pi]) begin
            checkOutput($sformatf("directed%0d_plane", pi), int'(plane), pin_val[pi]);
            pi++;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
